// File: rtl/timer_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi_pkg
// Purpose  : Shared time-format definitions and cascade helpers for the
//            multi-channel millisecond timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer_multi_pkg;

    // Packed time layout: {hr[4:0], min[5:0], sec[5:0], ms[9:0]}
    localparam int TIME_W  = 27;
    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int MS_W    = 10;
    localparam int MS_LSB  = 0;
    localparam int SEC_LSB = 10;
    localparam int MIN_LSB = 16;
    localparam int HR_LSB  = 22;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] mins;
        logic [SEC_W-1:0] secs;
        logic [MS_W-1:0]  ms;
    } time_t;

    typedef enum logic [0:0] {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    function automatic time_t unpack_time(input logic [TIME_W-1:0] v);
        time_t t;
        t.hr   = v[HR_LSB  +: HR_W];
        t.mins = v[MIN_LSB +: MIN_W];
        t.secs = v[SEC_LSB +: SEC_W];
        t.ms   = v[MS_LSB  +: MS_W];
        return t;
    endfunction

    function automatic logic [TIME_W-1:0] pack_time(input time_t t);
        return {t.hr, t.mins, t.secs, t.ms};
    endfunction

    // Largest representable time for a given hour ceiling
    function automatic time_t max_time(input logic [HR_W-1:0] hr_max);
        time_t t;
        t.hr   = hr_max;
        t.mins = MIN_MAX;
        t.secs = SEC_MAX;
        t.ms   = MS_MAX;
        return t;
    endfunction

    // Saturate each field independently to its legal maximum
    function automatic time_t clamp_time(input time_t t, input logic [HR_W-1:0] hr_max);
        time_t r;
        r.hr   = (t.hr   > hr_max)  ? hr_max  : t.hr;
        r.mins = (t.mins > MIN_MAX) ? MIN_MAX : t.mins;
        r.secs = (t.secs > SEC_MAX) ? SEC_MAX : t.secs;
        r.ms   = (t.ms   > MS_MAX)  ? MS_MAX  : t.ms;
        return r;
    endfunction

    // One-millisecond decrement with borrow cascade; caller guarantees t != 0
    function automatic time_t dec_time(input time_t t);
        time_t r;
        r = t;
        if (t.ms != '0) begin
            r.ms = t.ms - 10'd1;
        end else begin
            r.ms = MS_MAX;
            if (t.secs != '0) begin
                r.secs = t.secs - 6'd1;
            end else begin
                r.secs = SEC_MAX;
                if (t.mins != '0) begin
                    r.mins = t.mins - 6'd1;
                end else begin
                    r.mins = MIN_MAX;
                    r.hr   = t.hr - 5'd1;
                end
            end
        end
        return r;
    endfunction

    // One-millisecond increment with carry cascade; caller guarantees t < max
    function automatic time_t inc_time(input time_t t);
        time_t r;
        r = t;
        if (t.ms != MS_MAX) begin
            r.ms = t.ms + 10'd1;
        end else begin
            r.ms = '0;
            if (t.secs != SEC_MAX) begin
                r.secs = t.secs + 6'd1;
            end else begin
                r.secs = '0;
                if (t.mins != MIN_MAX) begin
                    r.mins = t.mins + 6'd1;
                end else begin
                    r.mins = '0;
                    r.hr   = t.hr + 5'd1;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi_if
// Purpose  : Control/status bundle between the user-entry path and the
//            multi-channel timer core.
// Revision : 1.0 - initial release
// ============================================================================
interface timer_multi_if #(
    parameter int N_CH = 4
);
    import timer_multi_pkg::*;

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CH_W-1:0]        sel_ch;
    logic                   load;
    logic                   toggle;
    logic [TIME_W-1:0]      preset_time;
    logic                   mode_up;
    logic                   auto_rld;
    logic [TIME_W*N_CH-1:0] out_time;
    logic [N_CH-1:0]        running;
    logic [N_CH-1:0]        expired;

    modport master (
        output sel_ch, load, toggle, preset_time, mode_up, auto_rld,
        input  out_time, running, expired
    );

    modport slave (
        input  sel_ch, load, toggle, preset_time, mode_up, auto_rld,
        output out_time, running, expired
    );

endinterface
`default_nettype wire

// File: rtl/timer_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Purpose  : One timer channel: preset/mode storage, run state and the
//            hr:min:sec.ms up/down cascade counter with auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              ld,
    input  logic              tog,
    input  logic [TIME_W-1:0] preset,
    input  logic              mode_up,
    input  logic              auto_rld,
    output logic [TIME_W-1:0] cur_time,
    output logic              running,
    output logic              expired
);

    localparam time_t c_max_time = max_time(HR_W'(HR_MAX));

    ch_state_t r_state,    w_state_nx;
    time_t     r_time,     w_time_nx;
    time_t     r_preset,   w_preset_nx;
    time_t     w_step;
    time_t     w_clamped;
    logic      r_mode_up,  w_mode_nx;
    logic      r_auto_rld, w_auto_nx;
    logic      r_expired,  w_exp_nx;
    logic      w_at_term;
    logic      w_step_term;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= CH_STOP;
            r_time     <= '0;
            r_preset   <= '0;
            r_mode_up  <= 1'b0;
            r_auto_rld <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_time     <= w_time_nx;
            r_preset   <= w_preset_nx;
            r_mode_up  <= w_mode_nx;
            r_auto_rld <= w_auto_nx;
            r_expired  <= w_exp_nx;
        end
    end

    // Next state: load beats everything; a tick acts on the old run state,
    // then a toggle flips it (start refused at the terminal value)
    always_comb begin
        w_state_nx  = r_state;
        w_time_nx   = r_time;
        w_preset_nx = r_preset;
        w_mode_nx   = r_mode_up;
        w_auto_nx   = r_auto_rld;
        w_exp_nx    = 1'b0;
        w_clamped   = clamp_time(unpack_time(preset), HR_W'(HR_MAX));
        w_at_term   = r_mode_up ? (r_time == c_max_time) : (r_time == '0);
        w_step      = r_mode_up ? inc_time(r_time) : dec_time(r_time);
        w_step_term = r_mode_up ? (w_step == c_max_time) : (w_step == '0);

        if (ld) begin
            w_time_nx   = w_clamped;
            w_preset_nx = w_clamped;
            w_mode_nx   = mode_up;
            w_auto_nx   = auto_rld;
            w_state_nx  = CH_STOP;
        end else begin
            if (tick && (r_state == CH_RUN)) begin
                if (w_at_term) begin
                    // Only reachable while auto-reloading: terminal value was shown for one tick
                    w_time_nx = r_preset;
                end else begin
                    w_time_nx = w_step;
                    if (w_step_term) begin
                        w_exp_nx = 1'b1;
                        if (!r_auto_rld) begin
                            w_state_nx = CH_STOP;
                        end
                    end
                end
            end
            if (tog) begin
                if (r_state == CH_RUN) begin
                    w_state_nx = CH_STOP;
                end else if (!w_at_term) begin
                    w_state_nx = CH_RUN;
                end
            end
        end
    end

    assign cur_time = pack_time(r_time);
    assign running  = (r_state == CH_RUN);
    assign expired  = r_expired;

endmodule
`default_nettype wire

// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : N-channel millisecond timer core with shared tick prescaler,
//            channel select decode and packed status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int HR_MAX  = 23
) (
    input  logic         clk,
    input  logic         reset,
    timer_multi_if.slave bus
);

    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_div   = CLK_HZ / TICK_HZ;
    localparam int c_pre_w = (c_div > 1) ? $clog2(c_div) : 1;

    logic [c_pre_w-1:0]     r_pre;
    logic                   w_tick;
    wire [TIME_W*N_CH-1:0]  w_out_time;
    wire [N_CH-1:0]         w_running;
    wire [N_CH-1:0]         w_expired;

    assign w_tick = (r_pre == c_pre_w'(c_div - 1));

    // Free-running prescaler; its wrap cycle is the shared count tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_w'(1);
        end
    end

    // Per-channel instance; out-of-range selects match no channel
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic w_sel;
        assign w_sel = (bus.sel_ch == CH_W'(k));

        timer_channel #(
            .HR_MAX   (HR_MAX)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (w_tick),
            .ld       (bus.load & w_sel),
            .tog      (bus.toggle & w_sel),
            .preset   (bus.preset_time),
            .mode_up  (bus.mode_up),
            .auto_rld (bus.auto_rld),
            .cur_time (w_out_time[TIME_W*k +: TIME_W]),
            .running  (w_running[k]),
            .expired  (w_expired[k])
        );
    end

    assign bus.out_time = w_out_time;
    assign bus.running  = w_running;
    assign bus.expired  = w_expired;

endmodule
`default_nettype wire
